mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-word memory port (dmem_* style: addr/wdata/wstrb/read/write, rdata/ready) between NUM_REQ requesters, e.g. I-side fetch and the D-cache fill/writeback path.
- Sits between the cache controllers and the backing memory model.
- Grants one requester per transaction, forwards its request unchanged, and routes ready/rdata back to that requester only.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- NUM_REQ, 2, number of requesters (>=2); index width GW = $clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address (requester k at slice k)
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  per-requester write data
- req_wstrb_i  in  NUM_REQ*DATA_WIDTH/8  per-requester byte strobes
- req_write_i  in  NUM_REQ  write request
- req_read_i  in  NUM_REQ  read request
- req_rdata_o  out  DATA_WIDTH  read data, shared bus, valid only with matching req_ready_o bit
- req_ready_o  out  NUM_REQ  one-hot completion
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_wstrb_o  out  DATA_WIDTH/8  memory strobes
- mem_write_o  out  1  memory write
- mem_read_o  out  1  memory read
- mem_rdata_i  in  DATA_WIDTH  memory read data
- mem_ready_i  in  1  memory completion
- grant_o  out  GW  index of current owner, valid while busy_o
- busy_o  out  1  a transaction is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; grant 0; rr pointer 0; busy_o 0; all mem_* and req_ready_o 0; req_rdata_o 0.
- Requester k is active when req_read_i[k] | req_write_i[k].
  - A requester holds its request stable until its req_ready_o bit pulses.
  - Read and write asserted together on one requester is illegal. The arbiter forwards both; behaviour is undefined.
- IDLE state:
  - If any requester is active, register the winner into grant and go to BUSY.
  - Nothing is driven to memory in this cycle: one cycle of arbitration latency.
- BUSY state:
  - mem_* outputs are driven combinationally from the granted requester's slice.
  - On mem_ready_i: req_ready_o[grant]=1 and req_rdata_o=mem_rdata_i in the same cycle, then return to IDLE.
  - One idle bubble follows between back-to-back transactions.
- Ownership is locked for the whole transaction:
  - Requests from other requesters are ignored until completion.
  - If the owner drops its request mid-transaction, the arbiter still drives the latched grant's live inputs and waits for mem_ready_i. Requester protocol forbids this case.
- mem_ready_i in IDLE is ignored; no req_ready_o is generated.
- Reset asserted in BUSY abandons the transaction next edge. The memory model must tolerate a dropped request.
- Outputs are never asserted for more than one requester.
- Counters: txn_count[k] (32-bit, wrapping) increments on each completed transaction of requester k. Readable hierarchically only for the bench; no port.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- Defined:
  - Round-robin arbitration. Search starts at rr_ptr and wraps modulo NUM_REQ.
  - On each grant, rr_ptr <= (winner+1) mod NUM_REQ.
- Undefined:
  - Fixed priority; the lowest index wins.
  - rr_ptr is not implemented.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e {ArbIdle, ArbBusy}
  - typedef mem_req_t struct: addr, wdata, wstrb, read, write
  - Helper function for the packed-slice index.
- Sub-module arb_pick: combinational requester vector plus pointer in, winner index and any-valid out. It implements both priority modes, selected by the macro.

Test Plan:
- Single read, rst low: req_read_i[1]=1, addr 0x100; memory returns 0xDEADBEEF after 3 cycles.
  - Required: mem_read_o rises 1 cycle after the request.
  - Required: req_ready_o=2'b10 with rdata 0xDEADBEEF exactly on the mem_ready_i cycle; busy_o falls the next cycle.
- Simultaneous requests: both requesters active at once; requester 0 writes 0x11223344 with wstrb 4'b0011.
  - Fixed priority: requester 0 served first and mem_wstrb_o=4'b0011; requester 1 served after one idle cycle.
  - Round-robin: the second simultaneous burst is served 1-then-0.
- Starvation check, round-robin: both requesters held continuously for 20 transactions.
  - Required: txn_count[0] and txn_count[1] are each 10, and grants alternate.
- Lock: requester 0 granted; requester 1 raises a request while memory stalls 5 cycles.
  - Required: mem_addr_o stays requester 0's address throughout, and req_ready_o[1] stays 0.
- Reset mid-transaction: assert rst in BUSY for 1 cycle.
  - Required: next cycle busy_o=0 and all mem_* outputs are 0.
  - Required: a new request is granted normally afterwards.
- Spurious ready: pulse mem_ready_i in IDLE.
  - Required: no req_ready_o bit asserts and the state is unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// The request struct is sized to upper bounds so a single type serves any instance width.
package mem_arb_pkg;

  typedef enum logic {ArbIdle, ArbBusy} arb_state_e;

  localparam int ARB_ADDR_MAX = 64;
  localparam int ARB_DATA_MAX = 256;
  localparam int ARB_STRB_MAX = ARB_DATA_MAX / 8;

  typedef struct packed {
    logic [ARB_ADDR_MAX-1:0] addr;
    logic [ARB_DATA_MAX-1:0] wdata;
    logic [ARB_STRB_MAX-1:0] wstrb;
    logic                    read;
    logic                    write;
  } mem_req_t;

  // Low bit of requester idx's field inside a flattened per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select over a request vector.
// MEM_ARB_ROUND_ROBIN_EN: search starts at ptr_i; otherwise lowest index wins.
module arb_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] idx_o,
  output logic          any_o
);

  int start;
  int c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign start = int'(ptr_i);
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start      = 0;
`endif

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = start + i;
      if (c >= N) c = c - N;
      if (!any_o && req_i[c]) begin
        idx_o = GW'(c);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-word memory port among NUM_REQ requesters, one locked transaction at a time.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 2,
  localparam int SW         = DATA_WIDTH / 8,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ*SW-1:0]         req_wstrb_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ-1:0]            req_read_i,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [SW-1:0]                 mem_wstrb_o,
  output logic                          mem_write_o,
  output logic                          mem_read_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic                          mem_ready_i,
  output logic [GW-1:0]                 grant_o,
  output logic                          busy_o
);

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [31:0]         txn_count_q [NUM_REQ];
  logic [31:0]         txn_count_d [NUM_REQ];
  logic [NUM_REQ-1:0]  active;
  logic [GW-1:0]       win;
  logic                any;
  logic [GW-1:0]       ptr;
  mem_req_t            sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
`else
  assign ptr = '0;
`endif

  assign active = req_read_i | req_write_i;

  arb_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
    .req_i (active),
    .ptr_i (ptr),
    .idx_o (win),
    .any_o (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) txn_count_q[k] <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      for (int k = 0; k < NUM_REQ; k++) txn_count_q[k] <= txn_count_d[k];
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    txn_count_d = txn_count_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ArbIdle: begin
        if (any) begin
          grant_d = win;
          state_d = ArbBusy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + GW'(1);
`endif
        end
      end
      ArbBusy: begin
        if (mem_ready_i) begin
          state_d              = ArbIdle;
          txn_count_d[grant_q] = txn_count_q[grant_q] + 32'd1;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Memory sees the owner's live inputs only while busy; zero otherwise.
  always_comb begin
    sel         = '0;
    req_ready_o = '0;
    req_rdata_o = '0;
    if (state_q == ArbBusy) begin
      sel.addr  = ARB_ADDR_MAX'(req_addr_i[slice_lo(int'(grant_q), ADDR_WIDTH) +: ADDR_WIDTH]);
      sel.wdata = ARB_DATA_MAX'(req_wdata_i[slice_lo(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH]);
      sel.wstrb = ARB_STRB_MAX'(req_wstrb_i[slice_lo(int'(grant_q), SW) +: SW]);
      sel.read  = req_read_i[grant_q];
      sel.write = req_write_i[grant_q];
      if (mem_ready_i) begin
        req_ready_o[grant_q] = 1'b1;
        req_rdata_o          = mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = sel.addr[ADDR_WIDTH-1:0];
  assign mem_wdata_o = sel.wdata[DATA_WIDTH-1:0];
  assign mem_wstrb_o = sel.wstrb[SW-1:0];
  assign mem_read_o  = sel.read;
  assign mem_write_o = sel.write;
  assign busy_o      = (state_q == ArbBusy);
  assign grant_o     = grant_q;

  logic unused_sel;
  assign unused_sel = ^{sel.addr, sel.wdata, sel.wstrb};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-table bench for mem_port_arbiter, with hand sequences for reset,
// continuous contention and (under MEM_ARB_ROUND_ROBIN_EN) pointer rotation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic [1:0]  req_write_i, req_read_i;
  logic [31:0] req_rdata_o;
  logic [1:0]  req_ready_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_write_o, mem_read_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic [0:0]  grant_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_write_i(req_write_i), .req_read_i(req_read_i),
    .req_rdata_o(req_rdata_o), .req_ready_o(req_ready_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct {
    string       name;
    logic [1:0]  rd, wr;
    logic        mrdy;
    logic [31:0] mrdata;
    logic        ebusy, egnt, emrd, emwr;
    logic [31:0] eaddr;
    logic [1:0]  erdy;
    logic [31:0] erdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(string n, logic [1:0] rd, logic [1:0] wr, logic mrdy,
                               logic [31:0] mrdata, logic ebusy, logic egnt, logic emrd,
                               logic emwr, logic [31:0] eaddr, logic [1:0] erdy,
                               logic [31:0] erdata);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.mrdy = mrdy; v.mrdata = mrdata;
    v.ebusy = ebusy; v.egnt = egnt; v.emrd = emrd; v.emwr = emwr;
    v.eaddr = eaddr; v.erdy = erdy; v.erdata = erdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Apply one row's inputs for a cycle, check combinational outputs mid-cycle.
  task automatic step(input vec_t v);
    req_read_i  = v.rd;
    req_write_i = v.wr;
    mem_ready_i = v.mrdy;
    mem_rdata_i = v.mrdata;
    @(negedge clk);
    chk({v.name, ".busy"},  64'(busy_o),      64'(v.ebusy));
    chk({v.name, ".ready"}, 64'(req_ready_o), 64'(v.erdy));
    chk({v.name, ".mrd"},   64'(mem_read_o),  64'(v.emrd));
    chk({v.name, ".mwr"},   64'(mem_write_o), 64'(v.emwr));
    chk({v.name, ".maddr"}, 64'(mem_addr_o),  64'(v.eaddr));
    if (v.ebusy) chk({v.name, ".grant"}, 64'(grant_o), 64'(v.egnt));
    if (v.emwr) begin
      chk({v.name, ".wstrb"}, 64'(mem_wstrb_o), v.egnt ? 64'hF : 64'h3);
      chk({v.name, ".wdata"}, 64'(mem_wdata_o), v.egnt ? 64'h55667788 : 64'h11223344);
    end
    if (v.erdy != 2'b00) chk({v.name, ".rdata"}, 64'(req_rdata_o), 64'(v.erdata));
    @(posedge clk); #1;
  endtask

  initial begin
    int done;
    logic g;

    req_addr_i  = {32'h0000_0100, 32'h0000_0200};
    req_wdata_i = {32'h5566_7788, 32'h1122_3344};
    req_wstrb_i = {4'hF, 4'h3};
    req_read_i  = '0;
    req_write_i = '0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    rst         = 1'b1;

    // Reset state, with a stray ready on the memory side that must not leak out.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.busy",  64'(busy_o),      64'h0);
    chk("rst.grant", 64'(grant_o),     64'h0);
    chk("rst.ready", 64'(req_ready_o), 64'h0);
    chk("rst.rdata", 64'(req_rdata_o), 64'h0);
    chk("rst.mem",   {mem_addr_o, mem_wdata_o}, 64'h0);
    chk("rst.ctl",   64'({mem_wstrb_o, mem_read_o, mem_write_o}), 64'h0);
    chk("rst.cnt0",  64'(dut.txn_count_q[0]), 64'h0);
    chk("rst.cnt1",  64'(dut.txn_count_q[1]), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready_i = 1'b0;

    //                  name    rd     wr     mrdy  mrdata         busy gnt mrd mwr addr      rdy    rdata
    tbl.push_back(row("t1c0", 2'b10, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("t1c1", 2'b10, 2'b00, 1'b0, 32'h0,          1,   1,  1,  0,  32'h100, 2'b00, 32'h0));
    tbl.push_back(row("t1c2", 2'b10, 2'b00, 1'b0, 32'h0,          1,   1,  1,  0,  32'h100, 2'b00, 32'h0));
    tbl.push_back(row("t1c3", 2'b10, 2'b00, 1'b1, 32'hDEADBEEF,   1,   1,  1,  0,  32'h100, 2'b10, 32'hDEADBEEF));
    tbl.push_back(row("t1c4", 2'b00, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("t2c0", 2'b10, 2'b01, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("t2c1", 2'b10, 2'b01, 1'b0, 32'h0,          1,   0,  0,  1,  32'h200, 2'b00, 32'h0));
    tbl.push_back(row("t2c2", 2'b10, 2'b01, 1'b1, 32'h0,          1,   0,  0,  1,  32'h200, 2'b01, 32'h0));
    tbl.push_back(row("t2c3", 2'b10, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("t2c4", 2'b10, 2'b00, 1'b1, 32'hCAFE0001,   1,   1,  1,  0,  32'h100, 2'b10, 32'hCAFE0001));
    tbl.push_back(row("t2c5", 2'b00, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("spc0", 2'b00, 2'b00, 1'b1, 32'h12345678,   0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("spc1", 2'b00, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("lkc0", 2'b01, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(row($sformatf("lkc%0d", i), 2'b11, 2'b00, 1'b0, 32'h0, 1, 0, 1, 0, 32'h200, 2'b00, 32'h0));
    tbl.push_back(row("lkc6", 2'b11, 2'b00, 1'b1, 32'hA5A5A5A5,   1,   0,  1,  0,  32'h200, 2'b01, 32'hA5A5A5A5));
    tbl.push_back(row("lkc7", 2'b10, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));
    tbl.push_back(row("lkc8", 2'b10, 2'b00, 1'b1, 32'h5A5A5A5A,   1,   1,  1,  0,  32'h100, 2'b10, 32'h5A5A5A5A));
    tbl.push_back(row("lkc9", 2'b00, 2'b00, 1'b0, 32'h0,          0,   0,  0,  0,  32'h0,   2'b00, 32'h0));

    foreach (tbl[i]) step(tbl[i]);
    chk("cnt0.after_table", 64'(dut.txn_count_q[0]), 64'd2);
    chk("cnt1.after_table", 64'(dut.txn_count_q[1]), 64'd3);

    // Reset while busy drops the transaction; the held request is re-granted.
    req_read_i = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.pre", 64'(busy_o), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstbusy.busy",  64'(busy_o), 64'h0);
    chk("rstbusy.mem",   {mem_addr_o, mem_wdata_o}, 64'h0);
    chk("rstbusy.ctl",   64'({mem_wstrb_o, mem_read_o, mem_write_o}), 64'h0);
    chk("rstbusy.cnt1",  64'(dut.txn_count_q[1]), 64'h0);
    @(posedge clk); #1;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_0077;
    @(negedge clk);
    chk("rstbusy.regrant", 64'({busy_o, grant_o}), 64'h3);
    chk("rstbusy.ready",   64'(req_ready_o), 64'h2);
    chk("rstbusy.rdata",   64'(req_rdata_o), 64'h77);
    @(posedge clk); #1;
    req_read_i  = 2'b00;
    mem_ready_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters held for 20 transactions, memory answers immediately.
    req_read_i = 2'b11;
    mem_rdata_i = 32'h0;
    done = 0;
    for (int cyc = 0; cyc < 200 && done < 20; cyc++) begin
      @(negedge clk);
      if (busy_o) begin
        mem_ready_i = 1'b1;
        #1;
        g = grant_o;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk($sformatf("starve.grant%0d", done), 64'(g), 64'(done % 2));
`else
        chk($sformatf("starve.grant%0d", done), 64'(g), 64'h0);
`endif
        done++;
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
    end
    chk("starve.done", 64'(done), 64'd20);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("starve.cnt0", 64'(dut.txn_count_q[0]), 64'd10);
    chk("starve.cnt1", 64'(dut.txn_count_q[1]), 64'd10);
`else
    chk("starve.cnt0", 64'(dut.txn_count_q[0]), 64'd20);
    chk("starve.cnt1", 64'(dut.txn_count_q[1]), 64'd0);
`endif

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // A lone grant to 0 moves the pointer to 1, so the next contended burst goes 1 then 0.
    tbl.delete();
    tbl.push_back(row("rrc0", 2'b00, 2'b00, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0,   2'b00, 32'h0));
    tbl.push_back(row("rrc1", 2'b01, 2'b00, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0,   2'b00, 32'h0));
    tbl.push_back(row("rrc2", 2'b01, 2'b00, 1'b1, 32'h1, 1, 0, 1, 0, 32'h200, 2'b01, 32'h1));
    tbl.push_back(row("rrc3", 2'b11, 2'b00, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0,   2'b00, 32'h0));
    tbl.push_back(row("rrc4", 2'b11, 2'b00, 1'b1, 32'h2, 1, 1, 1, 0, 32'h100, 2'b10, 32'h2));
    tbl.push_back(row("rrc5", 2'b01, 2'b00, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0,   2'b00, 32'h0));
    tbl.push_back(row("rrc6", 2'b01, 2'b00, 1'b1, 32'h3, 1, 0, 1, 0, 32'h200, 2'b01, 32'h3));
    tbl.push_back(row("rrc7", 2'b00, 2'b00, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0,   2'b00, 32'h0));
    foreach (tbl[i]) step(tbl[i]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
